// File: rtl/frogger_pkg.sv
// Shared Frogger constants, game-state encoding and small helpers.
// The collision block takes its tile geometry from here as well.
package frogger_pkg;

    localparam logic [9:0] TILE_SIZE   = 10'd32;
    localparam logic [9:0] SCREEN_W    = 10'd640;
    localparam logic [9:0] SCREEN_H    = 10'd480;
    localparam logic [1:0] START_LIVES = 2'd3;
    localparam logic [3:0] MAX_LEVEL   = 4'd15;

    typedef enum logic [1:0] {
        ALIVE = 2'd0,
        DYING = 2'd1,
        WON   = 2'd2,
        OVER  = 2'd3
    } game_state_e;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } btn_vec_t;

    function automatic logic [3:0] level_inc(input logic [3:0] lvl);
        return (lvl == MAX_LEVEL) ? lvl : lvl + 4'd1;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One push-button: 2-FF synchronizer, consecutive-cycle debounce counter,
// and a registered one-cycle press pulse on the debounced 0->1 edge.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int unsigned      CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             level_prev_q;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every output of this block gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        press_d = level_q & ~level_prev_q;
    end

    // NOTE: non-blocking assignments make each flop sample pre-edge values; blocking ones would merge the sync stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            press_q      <= press_d;
            cnt_q        <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/frog_controller.sv
// Frog position and game-state sequencer: debounced button moves, lives,
// level count, respawn freeze and game-over handling.
module frog_controller
    import frogger_pkg::*;
#(
    parameter logic [9:0]  START_X         = 10'd320,
    parameter logic [9:0]  START_Y         = 10'd448,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned RESPAWN_CYCLES  = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       death_collision,
    input  logic       win_collision,
    output logic [9:0] frog_x,
    output logic [9:0] frog_y,
    output logic [1:0] lives,
    output logic [3:0] level,
    output logic       frozen,
    output logic       game_over
);

    localparam int unsigned       RESP_W    = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;
    localparam logic [RESP_W-1:0] RESP_LAST = RESP_W'(RESPAWN_CYCLES - 1);
    localparam logic [9:0]        X_MAX     = SCREEN_W - TILE_SIZE;
    localparam logic [9:0]        Y_MAX     = SCREEN_H - TILE_SIZE;

    logic [3:0] raw_v;
    logic [3:0] press_v;
    logic [3:0] unused_level;
    btn_vec_t   press;

    assign raw_v = {btn_up, btn_down, btn_left, btn_right};
    assign press = btn_vec_t'(press_v);

    for (genvar i = 0; i < 4; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .rst    (rst),
            .btn_raw(raw_v[i]),
            .level  (unused_level[i]),
            .press  (press_v[i])
        );
    end

    game_state_e       state_q, state_d;
    logic [9:0]        x_q, x_d;
    logic [9:0]        y_q, y_d;
    logic [1:0]        lives_q, lives_d;
    logic [3:0]        level_q, level_d;
    logic              frozen_q, frozen_d;
    logic              over_q, over_d;
    logic [RESP_W-1:0] resp_cnt_q, resp_cnt_d;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        lives_d    = lives_q;
        level_d    = level_q;
        resp_cnt_d = '0;

        case (state_q)
            ALIVE: begin
                // Death beats win, and either collision beats a move in the same cycle.
                if (death_collision) begin
                    lives_d = lives_q - 2'd1;
                    state_d = (lives_q == 2'd1) ? OVER : DYING;
                end else if (win_collision) begin
                    level_d = level_inc(level_q);
                    state_d = WON;
                end else if (press.up) begin
                    if (y_q != '0) y_d = y_q - TILE_SIZE;
                end else if (press.down) begin
                    if (y_q != Y_MAX) y_d = y_q + TILE_SIZE;
                end else if (press.left) begin
                    if (x_q != '0) x_d = x_q - TILE_SIZE;
                end else if (press.right) begin
                    if (x_q != X_MAX) x_d = x_q + TILE_SIZE;
                end
            end
            DYING, WON: begin
                if (resp_cnt_q == RESP_LAST) begin
                    state_d = ALIVE;
                    x_d     = START_X;
                    y_d     = START_Y;
                end else begin
                    resp_cnt_d = resp_cnt_q + RESP_W'(1);
                end
            end
            OVER: begin
                if (|press_v) begin
                    state_d = ALIVE;
                    x_d     = START_X;
                    y_d     = START_Y;
                    lives_d = START_LIVES;
                    level_d = '0;
                end
            end
            default: state_d = ALIVE;
        endcase

        frozen_d = (state_d == DYING) || (state_d == WON);
        over_d   = (state_d == OVER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ALIVE;
            x_q        <= START_X;
            y_q        <= START_Y;
            lives_q    <= START_LIVES;
            level_q    <= '0;
            frozen_q   <= 1'b0;
            over_q     <= 1'b0;
            resp_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            lives_q    <= lives_d;
            level_q    <= level_d;
            frozen_q   <= frozen_d;
            over_q     <= over_d;
            resp_cnt_q <= resp_cnt_d;
        end
    end

    assign frog_x    = x_q;
    assign frog_y    = y_q;
    assign lives     = lives_q;
    assign level     = level_q;
    assign frozen    = frozen_q;
    assign game_over = over_q;

endmodule

// File: tb/tb_frog_controller.sv
// Self-checking bench for frog_controller: directed tables and sequences plus
// randomized stimulus checked every cycle against a behavioural game model.
module tb_frog_controller;

    localparam int D = 4;
    localparam int R = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic       death_collision, win_collision;
    logic [9:0] frog_x, frog_y;
    logic [1:0] lives;
    logic [3:0] level;
    logic       frozen, game_over;

    always #5 clk = ~clk;

    frog_controller #(
        .START_X        (10'd320),
        .START_Y        (10'd448),
        .DEBOUNCE_CYCLES(D),
        .RESPAWN_CYCLES (R)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .btn_up         (btn_up),
        .btn_down       (btn_down),
        .btn_left       (btn_left),
        .btn_right      (btn_right),
        .death_collision(death_collision),
        .win_collision  (win_collision),
        .frog_x         (frog_x),
        .frog_y         (frog_y),
        .lives          (lives),
        .level          (level),
        .frozen         (frozen),
        .game_over      (game_over)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Game state: 0 alive, 1 dying, 2 won, 3 over. Freeze ends at absolute edge m_end.
    int m_x = 320, m_y = 448, m_lives = 3, m_level = 0, m_st = 0, m_end = 0;
    int cyc = 0;
    bit m_lvl[4], m_lvl_d1[4], m_press[4];
    bit hist[4][D+2];   // hist[b][j] = raw sample taken j edges ago

    task automatic model_reset_game();
        m_x = 320; m_y = 448; m_lives = 3; m_level = 0; m_st = 0;
    endtask

    task automatic model_step();
        bit raw[4];
        bit new_press, all_diff;
        raw[0] = btn_up; raw[1] = btn_down; raw[2] = btn_left; raw[3] = btn_right;
        cyc++;
        if (rst) begin
            model_reset_game();
            for (int b = 0; b < 4; b++) begin
                m_lvl[b] = 0; m_lvl_d1[b] = 0; m_press[b] = 0;
                for (int j = 0; j < D + 2; j++) hist[b][j] = 0;
            end
            return;
        end
        case (m_st)
            0: begin
                if (death_collision) begin
                    m_st = (m_lives == 1) ? 3 : 1;
                    m_lives--;
                    m_end = cyc + R;
                end else if (win_collision) begin
                    m_level = (m_level < 15) ? m_level + 1 : 15;
                    m_st = 2;
                    m_end = cyc + R;
                end else if (m_press[0]) begin
                    if (m_y > 0) m_y -= 32;
                end else if (m_press[1]) begin
                    if (m_y < 448) m_y += 32;
                end else if (m_press[2]) begin
                    if (m_x > 0) m_x -= 32;
                end else if (m_press[3]) begin
                    if (m_x < 608) m_x += 32;
                end
            end
            1, 2: begin
                if (cyc == m_end) begin
                    m_st = 0; m_x = 320; m_y = 448;
                end
            end
            default: begin
                if (m_press[0] || m_press[1] || m_press[2] || m_press[3]) model_reset_game();
            end
        endcase
        // Debounced level flips once the last D synchronized samples (raw delayed 2) all disagree with it.
        for (int b = 0; b < 4; b++) begin
            new_press = m_lvl[b] && !m_lvl_d1[b];
            m_lvl_d1[b] = m_lvl[b];
            for (int j = D + 1; j > 0; j--) hist[b][j] = hist[b][j-1];
            hist[b][0] = raw[b];
            all_diff = 1;
            for (int j = 2; j <= D + 1; j++) if (hist[b][j] == m_lvl[b]) all_diff = 0;
            if (all_diff) m_lvl[b] = !m_lvl[b];
            m_press[b] = new_press;
        end
    endtask

    task automatic compare_model();
        check("model_x", int'(frog_x), m_x);
        check("model_y", int'(frog_y), m_y);
        check("model_lives", int'(lives), m_lives);
        check("model_level", int'(level), m_level);
        check("model_frozen", int'(frozen), int'(m_st == 1 || m_st == 2));
        check("model_game_over", int'(game_over), int'(m_st == 3));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic set_btns(input logic [3:0] b);
        {btn_up, btn_down, btn_left, btn_right} = b;
    endtask

    task automatic pulse(input logic [3:0] b);
        set_btns(b);
        repeat (D + 4) tick();
        set_btns(4'b0000);
        repeat (D + 4) tick();
    endtask

    task automatic check_all(input string name, input int x, input int y, input int lv,
                             input int lvl, input int fz, input int ov);
        check({name, "_x"}, int'(frog_x), x);
        check({name, "_y"}, int'(frog_y), y);
        check({name, "_lives"}, int'(lives), lv);
        check({name, "_level"}, int'(level), lvl);
        check({name, "_frozen"}, int'(frozen), fz);
        check({name, "_game_over"}, int'(game_over), ov);
    endtask

    task automatic count_frozen(output int n);
        n = 0;
        while (frozen && n < 40) begin
            n++;
            tick();
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [3:0] btns;   // {up, down, left, right}
        int         exp_x;
        int         exp_y;
    } move_vec_t;

    move_vec_t tbl[10];
    int        hold[4];
    int        nf;

    initial begin
        tbl[0] = '{4'b0011, 288, 416};  // left+right together: left wins
        tbl[1] = '{4'b0001, 320, 416};
        tbl[2] = '{4'b1100, 320, 384};  // up beats down
        tbl[3] = '{4'b0100, 320, 416};
        tbl[4] = '{4'b0100, 320, 448};
        tbl[5] = '{4'b0100, 320, 448};  // bottom edge
        tbl[6] = '{4'b1011, 320, 416};
        tbl[7] = '{4'b0110, 320, 448};
        tbl[8] = '{4'b0010, 288, 448};
        tbl[9] = '{4'b0001, 320, 448};

        rst = 1'b1;
        set_btns(4'b0000);
        death_collision = 1'b0;
        win_collision   = 1'b0;
        repeat (2) tick();
        check_all("reset", 320, 448, 3, 0, 0, 0);
        rst = 1'b0;

        // Hold up: exactly one move, 7 edges after the first sampling edge.
        btn_up = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t1_hold_up_y", int'(frog_y), (i >= 7) ? 416 : 448);
            check("t1_hold_up_x", int'(frog_x), 320);
        end
        btn_up = 1'b0;
        repeat (10) tick();

        // Bouncing input never stays stable long enough to register.
        for (int i = 0; i < 20; i++) begin
            btn_up = ((i >> 1) & 1) == 0;
            tick();
        end
        btn_up = 1'b0;
        repeat (10) tick();
        check("t2_bounce_y", int'(frog_y), 416);

        for (int i = 0; i < 10; i++) begin
            pulse(tbl[i].btns);
            check($sformatf("tbl%0d_x", i), int'(frog_x), tbl[i].exp_x);
            check($sformatf("tbl%0d_y", i), int'(frog_y), tbl[i].exp_y);
        end

        // Edge boundaries: right, top, left.
        repeat (9) pulse(4'b0001);
        check("t3_right_edge", int'(frog_x), 608);
        pulse(4'b0001);
        check("t3_right_clamp", int'(frog_x), 608);
        repeat (15) pulse(4'b1000);
        check("t3_top_clamp", int'(frog_y), 0);
        repeat (20) pulse(4'b0010);
        check("t3_left_clamp", int'(frog_x), 0);

        // Death with a press landing inside the freeze window.
        death_collision = 1'b1;
        btn_up = 1'b1;
        tick();
        death_collision = 1'b0;
        check_all("t4_death", 0, 0, 2, 0, 1, 0);
        count_frozen(nf);
        check("t4_freeze_cycles", nf, R);
        check_all("t4_respawn", 320, 448, 2, 0, 0, 0);
        btn_up = 1'b0;
        repeat (10) tick();
        check("t4_press_discarded_y", int'(frog_y), 448);

        // Death held through the respawn edge: only the first edge counts.
        death_collision = 1'b1;
        repeat (R + 1) tick();
        death_collision = 1'b0;
        check_all("t4_respawn_edge", 320, 448, 1, 0, 0, 0);

        win_collision = 1'b1;
        tick();
        win_collision = 1'b0;
        check_all("t5_win", 320, 448, 1, 1, 1, 0);
        repeat (R + 2) tick();
        pulse(4'b1000);
        check("t5_move_after_win", int'(frog_y), 416);

        // Last life: death beats win, game over, then any press restarts.
        death_collision = 1'b1;
        win_collision   = 1'b1;
        tick();
        death_collision = 1'b0;
        win_collision   = 1'b0;
        check_all("t5_over", 320, 416, 0, 1, 0, 1);
        repeat (3) tick();
        check("t5_over_held", int'(game_over), 1);
        pulse(4'b0010);
        check_all("t5_restart", 320, 448, 3, 0, 0, 0);

        // Level saturation, then reset in the middle of WON.
        for (int i = 0; i < 16; i++) begin
            win_collision = 1'b1;
            tick();
            win_collision = 1'b0;
            repeat (R + 1) tick();
        end
        check("t6_level_sat", int'(level), 15);
        pulse(4'b1000);
        win_collision = 1'b1;
        tick();
        win_collision = 1'b0;
        repeat (3) tick();
        check("t6_in_won", int'(frozen), 1);
        rst = 1'b1;
        tick();
        check_all("t6_reset_in_won", 320, 448, 3, 0, 0, 0);
        rst = 1'b0;

        // Randomized play checked cycle-by-cycle against the model.
        for (int b = 0; b < 4; b++) hold[b] = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] bv;
            bv = {btn_up, btn_down, btn_left, btn_right};
            for (int b = 0; b < 4; b++) begin
                if (hold[b] == 0) begin
                    bv[3-b]  = 1'($urandom_range(0, 1));
                    hold[b] = $urandom_range(1, 12);
                end
                hold[b]--;
            end
            set_btns(bv);
            death_collision = ($urandom_range(0, 59) == 0);
            win_collision   = ($urandom_range(0, 59) == 0);
            rst             = ($urandom_range(0, 799) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
